lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store unit directly downstream of the instruction controller. It consumes `memory_en`, `store_size` and `funct3` together with the ALU-computed address and the rs2 data. It runs one data-memory transaction per instruction over a req/ack bus, and stalls the core until that transaction completes. It returns sign- or zero-extended load data to the writeback mux (`wdSelect` = 01) and flags bus timeouts and misalignment.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum REQ cycles without `mem_ack` before an error; range 1..255.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high reset.
- `memory_en` in 1: current instruction accesses memory.
- `store_size` in 2: 00 byte, 01 half, 10 word, 11 load.
- `funct3` in 3: load kind; 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data (rs2).
- `load_data` out 32: extended load result; valid in DONE.
- `stall` out 1: hold PC and instruction.
- `lsu_err` out 1: one-cycle error pulse.
- `mem_req` out 1: bus request; registered.
- `mem_we` out 1: 1 for store.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: bus completion.
- `mem_rdata` in 32: read word; sampled on ack.

## Operation
FSM states are IDLE, REQ, DONE and ERR.

- **IDLE**
  - `memory_en`=0: stay in IDLE; `stall`=0.
  - `memory_en`=1: latch `addr`, `funct3`, `store_size` and the formatted bus fields, then go to REQ. `stall`=1 combinationally in this cycle.
- **REQ**
  - `mem_req`=1 and `stall`=1.
  - `mem_ack`=1: capture `mem_rdata`, then go to DONE.
  - Otherwise increment the timeout counter. When the counter reaches `TIMEOUT_CYCLES`, go to ERR.
  - If `mem_ack` arrives in the same cycle the count expires, the ack wins.
- **DONE**
  - `stall`=0 and `load_data` valid; the core advances at this edge.
  - Always go to IDLE. DONE never starts a new request.
- **ERR**
  - `lsu_err`=1, `stall`=0, `load_data`=0, no register effect on memory.
  - Go to IDLE.

Store formatting:
- Byte: `mem_be`=0001<<addr[1:0]; `mem_wdata`={4{wdata[7:0]}}.
- Half: `mem_be`=0011<<{addr[1],1'b0}; `mem_wdata`={2{wdata[15:0]}}.
- Word: `mem_be`=1111; `mem_wdata`=`wdata`.

Load formatting:
- `mem_be`=1111 and `mem_we`=0.
- The byte/half is selected by `addr[1:0]` (`addr[1]` for half).
- Sign extension for LB/LH; zero extension for LBU/LHU.
- Undefined `funct3` values are treated as LW.

## Timing
- Reset values:
  - State IDLE, counter 0, `load_data` 0.
  - `stall`, `lsu_err`, `mem_req`, `mem_we` are 0.
  - `mem_addr`, `mem_be`, `mem_wdata` are 0.
- Reset mid-REQ drops `mem_req` immediately (asynchronously); the bus must tolerate an abandoned request.
- Minimum occupancy is 3 cycles (IDLE detect, REQ with ack, DONE), with `stall` high for 2 of them.
- Each extra ack-wait cycle adds one cycle.
- Bus fields are stable for the whole of REQ. `mem_req` drops in the cycle after ack is seen.
- The timeout counter is 8 bits, cleared on entry to REQ, and never wraps, because REQ exits at `TIMEOUT_CYCLES` ≤ 255.
- `lsu_err` is high for exactly one cycle per failed instruction.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN`.
- **Defined:** in IDLE, a half access with `addr[0]`=1 or a word access with `addr[1:0]`≠0 goes directly to ERR. There is no bus request, and stall is high for 1 cycle.
- **Undefined:**
  - No misalignment check.
  - Half accesses ignore `addr[0]`.
  - Word accesses ignore `addr[1:0]`.

## Structure
- The shared core package holds:
  - The `store_size` encoding constants (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_LOAD`).
  - The load `funct3` constants.
  - The LSU state enum `lsu_state_t`.
- One combinational sub-module, `lsu_load_align`: input `mem_rdata`, `addr[1:0]`, `funct3`; output the extended 32-bit result.
- Store formatting stays inline.

## Test plan
- SW, `addr`=0x104, `wdata`=0xDEADBEEF, ack on first REQ cycle → `mem_be`=1111, `mem_addr`=0x104, `stall` high 2 cycles, DONE on cycle 3.
- SB, `addr`=0x103, `wdata`=0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- LB `addr`=0x102 and LBU `addr`=0x102, both with `mem_rdata`=0x12F4_5678 → LB gives `load_data`=0xFFFFFFF4; LBU gives 0x000000F4.
- LH, `addr`=0x102, `mem_rdata`=0x8001_0000, ack delayed 5 cycles → `load_data`=0xFFFF8001, `stall` high 6 cycles.
- LW, `TIMEOUT_CYCLES`=4, no ack → ERR after 4 REQ cycles; `lsu_err` pulses once, `load_data`=0. Separately, ack on the 4th REQ cycle → normal DONE.
- With the macro defined, LW at `addr`=0x102 → no `mem_req`, `lsu_err` pulse. Without the macro → `mem_addr`=0x100, normal load. Additionally, reset asserted mid-REQ → `mem_req`=0 and state IDLE immediately.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared core definitions for the load/store unit: size encodings, load funct3 codes and LSU states.
package lsu_mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_LOAD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } lsu_state_t;

    // Undefined load funct3 codes behave as LW, so anything not byte/half is a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic is_byte;
        logic is_half;
        is_byte = (size == SZ_BYTE) || ((size == SZ_LOAD) && ((f3 == F3_LB) || (f3 == F3_LBU)));
        is_half = (size == SZ_HALF) || ((size == SZ_LOAD) && ((f3 == F3_LH) || (f3 == F3_LHU)));
        if (is_byte) begin
            return 1'b0;
        end else if (is_half) begin
            return lo[0];
        end else begin
            return (lo != 2'b00);
        end
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_align.sv
// Lane selection and sign/zero extension of a loaded memory word.
module lsu_load_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane, then extend according to the load kind.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = 32'h0000_0000;
        case (addr_lo)
            2'd0:    byte_s = mem_rdata[7:0];
            2'd1:    byte_s = mem_rdata[15:8];
            2'd2:    byte_s = mem_rdata[23:16];
            2'd3:    byte_s = mem_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        case (funct3)
            F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   load_data = {{16{half_s[15]}}, half_s};
            F3_LBU:  load_data = {24'h00_0000, byte_s};
            F3_LHU:  load_data = {16'h0000, half_s};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one req/ack bus transaction per instruction, stalling the core until it ends.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_en,
    input  logic [1:0]  store_size,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  f3_q, f3_d;

    logic [3:0]  fmt_be_s;
    logic [31:0] fmt_wdata_s;
    logic        fmt_we_s;
    logic        misalign_s;
    logic [31:0] align_s;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = is_misaligned(store_size, funct3, addr[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    lsu_load_align u_align (
        .mem_rdata (mem_rdata),
        .addr_lo   (lo_q),
        .funct3    (f3_q),
        .load_data (align_s)
    );

    // Store lane formatting; loads read the whole word.
    always_comb begin
        fmt_be_s    = 4'b1111;
        fmt_wdata_s = 32'h0000_0000;
        fmt_we_s    = 1'b1;
        case (store_size)
            SZ_BYTE: begin
                fmt_be_s    = 4'b0001 << addr[1:0];
                fmt_wdata_s = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                fmt_be_s    = 4'b0011 << {addr[1], 1'b0};
                fmt_wdata_s = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                fmt_be_s    = 4'b1111;
                fmt_wdata_s = wdata;
            end
            default: begin
                fmt_we_s = 1'b0;
            end
        endcase
    end

    // State register and datapath flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'h00;
            load_data_q <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0000_0000;
            lo_q        <= 2'b00;
            f3_q        <= 3'b000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            lo_q        <= lo_d;
            f3_q        <= f3_d;
        end
    end

    // Next-state logic; an ack in the expiring cycle still completes normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (memory_en) begin
                    state_d = misalign_s ? ST_ERR : ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: bus fields frozen for the whole request, counter cleared on entry.
    always_comb begin
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        mem_req_d   = (state_d == ST_REQ);
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        lo_d        = lo_q;
        f3_d        = f3_q;
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            cnt_d       = 8'h00;
            mem_we_d    = fmt_we_s;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = fmt_be_s;
            mem_wdata_d = fmt_wdata_s;
            lo_d        = addr[1:0];
            f3_d        = funct3;
        end else if ((state_q == ST_REQ) && !mem_ack) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (state_d == ST_ERR) begin
            load_data_d = 32'h0000_0000;
        end else if ((state_q == ST_REQ) && mem_ack) begin
            load_data_d = mem_we_q ? 32'h0000_0000 : align_s;
        end else begin
            load_data_d = load_data_q;
        end
    end

    // Core-facing handshake outputs decoded from the current state.
    always_comb begin
        stall   = 1'b0;
        lsu_err = 1'b0;
        case (state_q)
            ST_IDLE: stall   = memory_en;
            ST_REQ:  stall   = 1'b1;
            ST_DONE: stall   = 1'b0;
            ST_ERR:  lsu_err = 1'b1;
            default: stall   = 1'b0;
        endcase
    end

    assign load_data = load_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: instance A uses the default timeout, instance B a 4-cycle timeout.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    typedef struct {
        string       name;
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
        int          stall;
        bit          has_req;
        logic [3:0]  be;
        logic [31:0] maddr;
        bit          chk_wdata;
        logic [31:0] mwdata;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   events = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        memory_en = 1'b0;
    logic [1:0]  store_size = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        en_a, en_b, ack_a, ack_b;
    logic [31:0] a_ld, b_ld, a_addr, b_addr, a_wd, b_wd;
    logic        a_stall, b_stall, a_err, b_err, a_req, b_req, a_we, b_we;
    logic [3:0]  a_be, b_be;

    assign en_a  = memory_en & ~sel;
    assign en_b  = memory_en & sel;
    assign ack_a = mem_ack & ~sel;
    assign ack_b = mem_ack & sel;

    lsu_mem_ctrl u_a (
        .clk(clk), .reset(reset), .memory_en(en_a), .store_size(store_size), .funct3(funct3),
        .addr(addr), .wdata(wdata), .load_data(a_ld), .stall(a_stall), .lsu_err(a_err),
        .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr), .mem_be(a_be), .mem_wdata(a_wd),
        .mem_ack(ack_a), .mem_rdata(mem_rdata)
    );

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) u_b (
        .clk(clk), .reset(reset), .memory_en(en_b), .store_size(store_size), .funct3(funct3),
        .addr(addr), .wdata(wdata), .load_data(b_ld), .stall(b_stall), .lsu_err(b_err),
        .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_be(b_be), .mem_wdata(b_wd),
        .mem_ack(ack_b), .mem_rdata(mem_rdata)
    );

    logic [31:0] m_ld, m_addr, m_wd;
    logic        m_stall, m_err, m_req, m_we;
    logic [3:0]  m_be;
    assign m_ld    = sel ? b_ld    : a_ld;
    assign m_stall = sel ? b_stall : a_stall;
    assign m_err   = sel ? b_err   : a_err;
    assign m_req   = sel ? b_req   : a_req;
    assign m_we    = sel ? b_we    : a_we;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_be    = sel ? b_be    : a_be;
    assign m_wd    = sel ? b_wd    : a_wd;

    always #5 clk = ~clk;

    function automatic exp_t mk(string n, bit err, bit chkd, logic [31:0] d, int st, bit req,
                                logic [3:0] be, logic [31:0] ma, bit chkw, logic [31:0] mw,
                                logic we);
        exp_t e;
        e.name = n; e.is_err = err; e.chk_data = chkd; e.data = d; e.stall = st;
        e.has_req = req; e.be = be; e.maddr = ma; e.chk_wdata = chkw; e.mwdata = mw; e.we = we;
        return e;
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", n, act, req);
        end
    endtask

    // Monitor: compares bus fields during REQ and the completion (DONE/ERR) against the queue head.
    initial begin
        bit   prev_stall = 1'b0;
        bit   req_seen = 1'b0;
        bit   err_prev = 1'b0;
        int   stall_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0; req_seen = 1'b0; err_prev = 1'b0; stall_cnt = 0;
            end else begin
                if (err_prev) check("err_one_cycle", {31'h0, m_err}, 32'h0);
                err_prev = 1'b0;
                if (m_req && exp_q.size() > 0) begin
                    req_seen = 1'b1;
                    check({exp_q[0].name, "_be"}, {28'h0, m_be}, {28'h0, exp_q[0].be});
                    check({exp_q[0].name, "_addr"}, m_addr, exp_q[0].maddr);
                    check({exp_q[0].name, "_we"}, {31'h0, m_we}, {31'h0, exp_q[0].we});
                    if (exp_q[0].chk_wdata) check({exp_q[0].name, "_wdata"}, m_wd, exp_q[0].mwdata);
                end
                if (m_stall) stall_cnt++;
                if (prev_stall && !m_stall) begin
                    events++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_lsu_err"}, {31'h0, m_err}, {31'h0, e.is_err});
                        check({e.name, "_stall_cycles"}, stall_cnt, e.stall);
                        check({e.name, "_req_seen"}, {31'h0, req_seen}, {31'h0, e.has_req});
                        check({e.name, "_req_dropped"}, {31'h0, m_req}, 32'h0);
                        if (e.chk_data) check({e.name, "_load_data"}, m_ld, e.data);
                    end
                    err_prev = m_err;
                    stall_cnt = 0;
                    req_seen = 1'b0;
                end
                prev_stall = m_stall;
            end
        end
    end

    // Issue one instruction; ack_at is the REQ cycle (1-based) carrying the ack, 0 for never.
    task automatic issue(input bit b, input logic [1:0] sz, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int ack_at, input exp_t e);
        int start;
        exp_q.push_back(e);
        sel = b; store_size = sz; funct3 = f3; addr = a; wdata = wd; mem_rdata = rd;
        start = events;
        memory_en = 1'b1;
        @(posedge clk); #1;
        memory_en = 1'b0;
        for (int i = 1; i <= 300 && events == start; i++) begin
            if (i == ack_at) mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        if (events == start) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no completion seen, expected one", e.name);
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_a_outputs", {a_ld, a_stall, a_err, a_req, a_we, a_be, 12'h0},
              {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h0});
        check("reset_a_addr_wdata", a_addr | a_wd, 32'h0);
        check("reset_b_outputs", {b_ld[31:0]} | b_addr | b_wd, 32'h0);
        check("reset_b_ctrl", {27'h0, b_stall, b_err, b_req, b_we, |b_be}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, SZ_WORD, F3_LW, 32'h104, 32'hDEAD_BEEF, 32'h0, 1,
              mk("sw", 0, 0, 32'h0, 2, 1, 4'hF, 32'h104, 1, 32'hDEAD_BEEF, 1'b1));
        issue(1'b0, SZ_BYTE, F3_LB, 32'h103, 32'h0000_00A5, 32'h0, 1,
              mk("sb", 0, 0, 32'h0, 2, 1, 4'h8, 32'h100, 1, 32'hA5A5_A5A5, 1'b1));
        issue(1'b0, SZ_BYTE, F3_LB, 32'h101, 32'h0000_003C, 32'h0, 1,
              mk("sb1", 0, 0, 32'h0, 2, 1, 4'h2, 32'h100, 1, 32'h3C3C_3C3C, 1'b1));
        issue(1'b0, SZ_HALF, F3_LH, 32'h102, 32'h1234_BEEF, 32'h0, 2,
              mk("sh", 0, 0, 32'h0, 3, 1, 4'hC, 32'h100, 1, 32'hBEEF_BEEF, 1'b1));
        issue(1'b0, SZ_LOAD, F3_LB, 32'h102, 32'h0, 32'h12F4_5678, 1,
              mk("lb", 0, 1, 32'hFFFF_FFF4, 2, 1, 4'hF, 32'h100, 0, 32'h0, 1'b0));
        issue(1'b0, SZ_LOAD, F3_LBU, 32'h102, 32'h0, 32'h12F4_5678, 1,
              mk("lbu", 0, 1, 32'h0000_00F4, 2, 1, 4'hF, 32'h100, 0, 32'h0, 1'b0));
        issue(1'b0, SZ_LOAD, F3_LB, 32'h103, 32'h0, 32'h7F00_0000, 1,
              mk("lb_pos", 0, 1, 32'h0000_007F, 2, 1, 4'hF, 32'h100, 0, 32'h0, 1'b0));
        issue(1'b0, SZ_LOAD, F3_LH, 32'h102, 32'h0, 32'h8001_0000, 5,
              mk("lh_slow", 0, 1, 32'hFFFF_8001, 6, 1, 4'hF, 32'h100, 0, 32'h0, 1'b0));
        issue(1'b0, SZ_LOAD, F3_LHU, 32'h100, 32'h0, 32'h8001_F00D, 1,
              mk("lhu", 0, 1, 32'h0000_F00D, 2, 1, 4'hF, 32'h100, 0, 32'h0, 1'b0));
        issue(1'b0, SZ_LOAD, F3_LW, 32'h100, 32'h0, 32'hCAFE_BABE, 2,
              mk("lw", 0, 1, 32'hCAFE_BABE, 3, 1, 4'hF, 32'h100, 0, 32'h0, 1'b0));
        issue(1'b0, SZ_LOAD, 3'b011, 32'h104, 32'h0, 32'h8765_4321, 1,
              mk("lw_f3_011", 0, 1, 32'h8765_4321, 2, 1, 4'hF, 32'h104, 0, 32'h0, 1'b0));
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, SZ_LOAD, F3_LW, 32'h102, 32'h0, 32'h0BAD_F00D, 0,
              mk("lw_misaligned", 1, 1, 32'h0, 1, 0, 4'hF, 32'h100, 0, 32'h0, 1'b0));
        issue(1'b0, SZ_HALF, F3_LH, 32'h101, 32'h0000_5566, 32'h0, 0,
              mk("sh_misaligned", 1, 1, 32'h0, 1, 0, 4'h3, 32'h100, 0, 32'h0, 1'b1));
`else
        issue(1'b0, SZ_LOAD, F3_LW, 32'h102, 32'h0, 32'h0BAD_F00D, 1,
              mk("lw_unaligned", 0, 1, 32'h0BAD_F00D, 2, 1, 4'hF, 32'h100, 0, 32'h0, 1'b0));
        issue(1'b0, SZ_HALF, F3_LH, 32'h101, 32'h0000_5566, 32'h0, 1,
              mk("sh_odd", 0, 0, 32'h0, 2, 1, 4'h3, 32'h100, 1, 32'h5566_5566, 1'b1));
`endif

        issue(1'b1, SZ_LOAD, F3_LW, 32'h300, 32'h0, 32'h5A5A_1234, 4,
              mk("b_ack_at_limit", 0, 1, 32'h5A5A_1234, 5, 1, 4'hF, 32'h300, 0, 32'h0, 1'b0));
        issue(1'b1, SZ_LOAD, F3_LW, 32'h300, 32'h0, 32'h0, 0,
              mk("b_timeout", 1, 1, 32'h0, 5, 1, 4'hF, 32'h300, 0, 32'h0, 1'b0));
        issue(1'b1, SZ_BYTE, F3_LB, 32'h302, 32'h0000_0011, 32'h0, 1,
              mk("b_after_err", 0, 0, 32'h0, 2, 1, 4'h4, 32'h300, 1, 32'h1111_1111, 1'b1));

        // Reset while a request is outstanding on A.
        sel = 1'b0; store_size = SZ_LOAD; funct3 = F3_LW; addr = 32'h200;
        memory_en = 1'b1;
        @(posedge clk); #1;
        memory_en = 1'b0;
        @(posedge clk); #1;
        check("mid_req_active", {31'h0, a_req}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_req_reset_req", {31'h0, a_req}, 32'h0);
        check("mid_req_reset_state", {30'h0, u_a.state_q}, {30'h0, ST_IDLE});
        check("mid_req_reset_stall", {31'h0, a_stall}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, SZ_LOAD, F3_LHU, 32'h202, 32'h0, 32'hABCD_0123, 1,
              mk("after_reset", 0, 1, 32'h0000_ABCD, 2, 1, 4'hF, 32'h200, 0, 32'h0, 1'b0));

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
